// File: rtl/circular_queue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cq_pkg
// Shared types and helpers for the circular queue controller.
//   cq_ptr_t    : queue pointer, wrap flag + value (value field sized for the
//                 largest supported depth; unused upper bits stay zero)
//   cq_ptr_inc  : pointer increment with wrap at an arbitrary depth
//   cq_empty    : empty test on an enqueue/dequeue pointer pair
//   cq_full     : full test on an enqueue/dequeue pointer pair
//   cq_idx_w    : requester index width, max(1, clog2(n))
// ---------------------------------------------------------------------------
package cq_pkg;

    localparam int unsigned CQ_VAL_W = 16;

    typedef struct packed {
        logic                flag;
        logic [CQ_VAL_W-1:0] val;
    } cq_ptr_t;

    // Wraps to zero and toggles the flag when val+1 reaches the depth, so
    // non-power-of-2 depths work.
    function automatic cq_ptr_t cq_ptr_inc(cq_ptr_t p, int unsigned entries);
        cq_ptr_t r;
        r = p;
        if (32'(p.val) + 32'd1 == entries) begin
            r.val  = '0;
            r.flag = ~p.flag;
        end else begin
            r.val = p.val + 1'b1;
        end
        return r;
    endfunction

    function automatic logic cq_empty(cq_ptr_t e, cq_ptr_t d);
        return (e.flag == d.flag) && (e.val == d.val);
    endfunction

    function automatic logic cq_full(cq_ptr_t e, cq_ptr_t d);
        return (e.flag != d.flag) && (e.val == d.val);
    endfunction

    function automatic int unsigned cq_idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/circular_queue_ctrl_if.sv
// ---------------------------------------------------------------------------
// circular_queue_ctrl_if
// Handshake and storage-port bundle of the circular queue controller.
//   flush_i      : synchronous flush request
//   enq_valid_i  : per-requester enqueue request   enq_ready_o : one-hot grant
//   enq_idx_o    : granted requester index
//   mem_we_o     : storage write strobe            mem_waddr_o : write address
//   deq_valid_o  : head valid                      deq_ready_i : head accepted
//   mem_raddr_o  : storage read address
//   full_o/empty_o : status
//   count_o      : occupancy, only with CQ_CTRL_COUNT_EN defined
// Modports: slave = controller, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface circular_queue_ctrl_if
    import cq_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned PTR_WIDTH = $clog2(ENTRIES);
    localparam int unsigned IDX_WIDTH = cq_idx_w(NUM_REQ);

    logic                 flush_i;
    logic [NUM_REQ-1:0]   enq_valid_i;
    logic [NUM_REQ-1:0]   enq_ready_o;
    logic [IDX_WIDTH-1:0] enq_idx_o;
    logic                 mem_we_o;
    logic [PTR_WIDTH-1:0] mem_waddr_o;
    logic                 deq_valid_o;
    logic                 deq_ready_i;
    logic [PTR_WIDTH-1:0] mem_raddr_o;
    logic                 full_o;
    logic                 empty_o;
`ifdef CQ_CTRL_COUNT_EN
    logic [PTR_WIDTH:0]   count_o;
`endif

    modport slave (
        input  flush_i, enq_valid_i, deq_ready_i,
        output enq_ready_o, enq_idx_o, mem_we_o, mem_waddr_o,
        output deq_valid_o, mem_raddr_o, full_o, empty_o
`ifdef CQ_CTRL_COUNT_EN
        , output count_o
`endif
    );

    modport master (
        output flush_i, enq_valid_i, deq_ready_i,
        input  enq_ready_o, enq_idx_o, mem_we_o, mem_waddr_o,
        input  deq_valid_o, mem_raddr_o, full_o, empty_o
`ifdef CQ_CTRL_COUNT_EN
        , input count_o
`endif
    );

endinterface

// File: rtl/circular_queue_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// NUM_REQ-wide round-robin arbiter owning the priority register.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous priority clear (queue flush)
//   en_i          : allow a grant this cycle
//   req_i         : request vector
//   adv_i         : a grant was taken; priority moves past the winner
//   grant_o       : one-hot grant (zero when disabled or no request)
//   idx_o         : winner index (zero when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter
    import cq_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           en_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic                           adv_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [cq_idx_w(NUM_REQ)-1:0]   idx_o
);
    localparam int unsigned IDX_WIDTH = cq_idx_w(NUM_REQ);

    logic [IDX_WIDTH-1:0] prio_q, prio_d;
    logic                 found;
    int unsigned          cand;

    // Scan from prio upward with explicit wrap; first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(prio_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (en_i && !found && req_i[IDX_WIDTH'(cand)]) begin
                found                      = 1'b1;
                grant_o[IDX_WIDTH'(cand)]  = 1'b1;
                idx_o                      = IDX_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (clear_i) begin
            prio_d = '0;
        end else if (adv_i && found) begin
            prio_d = (32'(idx_o) + 32'd1 >= NUM_REQ) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prio_q <= '0;
        else         prio_q <= prio_d;
    end

endmodule

// File: rtl/circular_queue_ctrl.sv
// ---------------------------------------------------------------------------
// circular_queue_ctrl
// Controller for one shared circular queue: round-robin arbitration of
// NUM_REQ enqueue lanes onto a single write port, flagged enqueue/dequeue
// pointers, full/empty, and addresses for an external combinational-read
// storage array.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   q      : circular_queue_ctrl_if.slave handshake/storage bundle
// Optional feature macro: CQ_CTRL_COUNT_EN adds the count_o occupancy output.
// ---------------------------------------------------------------------------
module circular_queue_ctrl
    import cq_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    circular_queue_ctrl_if.slave  q
);
    localparam int unsigned PTR_WIDTH = $clog2(ENTRIES);
    localparam int unsigned IDX_WIDTH = cq_idx_w(NUM_REQ);

    cq_ptr_t              enq_q, enq_d, deq_q, deq_d;
    logic                 empty, full, arb_en, enq_fire, deq_valid, deq_fire;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_WIDTH-1:0] grant_idx;

    assign empty  = cq_empty(enq_q, deq_q);
    assign full   = cq_full(enq_q, deq_q);
    // Full blocks grants even when a dequeue happens this cycle.
    assign arb_en = !full && !q.flush_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (q.flush_i),
        .en_i    (arb_en),
        .req_i   (q.enq_valid_i),
        .adv_i   (enq_fire),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    assign enq_fire  = |grant;
    assign deq_valid = !empty && !q.flush_i;
    assign deq_fire  = deq_valid && q.deq_ready_i;

    assign q.enq_ready_o = grant;
    assign q.enq_idx_o   = grant_idx;
    assign q.mem_we_o    = enq_fire;
    assign q.mem_waddr_o = enq_q.val[PTR_WIDTH-1:0];
    assign q.mem_raddr_o = deq_q.val[PTR_WIDTH-1:0];
    assign q.deq_valid_o = deq_valid;
    assign q.full_o      = full;
    assign q.empty_o     = empty;

`ifdef CQ_CTRL_COUNT_EN
    logic [PTR_WIDTH:0] enq_v, deq_v;
    always_comb begin
        enq_v = {1'b0, enq_q.val[PTR_WIDTH-1:0]};
        deq_v = {1'b0, deq_q.val[PTR_WIDTH-1:0]};
        if (enq_q.flag == deq_q.flag) q.count_o = enq_v - deq_v;
        else                          q.count_o = (PTR_WIDTH+1)'(ENTRIES) + enq_v - deq_v;
    end
`endif

    always_comb begin
        enq_d = enq_q;
        deq_d = deq_q;
        if (q.flush_i) begin
            enq_d = '0;
            deq_d = '0;
        end else begin
            if (enq_fire) enq_d = cq_ptr_inc(enq_q, ENTRIES);
            if (deq_fire) deq_d = cq_ptr_inc(deq_q, ENTRIES);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enq_q <= '0;
            deq_q <= '0;
        end else begin
            enq_q <= enq_d;
            deq_q <= deq_d;
        end
    end

endmodule
